// File: rtl/adder_bist_driver_if.sv
// Operand/result bundle between the BIST driver and the adder under test.
// The master side is the driver, which owns the operands and status.
interface adder_bist_driver_if;
  logic       start;
  logic [7:0] sum_in;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] vec_count;

  modport master (
    input  start, sum_in,
    output op_a, op_b, busy, done, pass, err_count, vec_count
  );

  modport slave (
    output start, sum_in,
    input  op_a, op_b, busy, done, pass, err_count, vec_count
  );
endinterface

// File: rtl/adder_bist_driver.sv
// BIST driver: feeds LFSR vectors to an external 8-bit adder and checks the
// returned sum after a programmable wait, counting vectors and mismatches.
module adder_bist_driver #(
  parameter int N_VECTORS = 16,
  parameter int LATENCY   = 0
) (
  input  logic               clk,
  input  logic               rst,
  adder_bist_driver_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [7:0]  N_VEC = 8'(N_VECTORS);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0];
  endfunction

  state_t      state_r, state_next;
  logic [15:0] lfsr_r, lfsr_next;
  logic [3:0]  wait_r, wait_next;
  logic [7:0]  err_r, err_next;
  logic [7:0]  vec_r, vec_next;
  logic        busy_r, busy_next;
  logic        done_r, done_next;
  logic        pass_r, pass_next;

  // Next-state, datapath and status decode; status is registered from next state.
  always_comb begin
    state_next = state_r;
    lfsr_next  = lfsr_r;
    wait_next  = wait_r;
    err_next   = err_r;
    vec_next   = vec_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = DRIVE;
          lfsr_next  = SEED;
          err_next   = 8'd0;
          vec_next   = 8'd0;
        end else begin
          state_next = state_r;
        end
      end
      DRIVE: begin
        wait_next = 4'd0;
        if (LAT != 4'd0) begin
          state_next = WAIT;
        end else begin
          state_next = CHECK;
        end
      end
      WAIT: begin
        if (wait_r == LAT - 4'd1) begin
          state_next = CHECK;
        end else begin
          wait_next = wait_r + 4'd1;
        end
      end
      CHECK: begin
        if ((bus.sum_in != add8(lfsr_r[15:8], lfsr_r[7:0])) && (err_r != 8'hFF)) begin
          err_next = err_r + 8'd1;
        end else begin
          err_next = err_r;
        end
        vec_next  = vec_r + 8'd1;
        lfsr_next = lfsr_step(lfsr_r);
        if (vec_next == N_VEC) begin
          state_next = DONE;
        end else begin
          state_next = DRIVE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next == DRIVE) || (state_next == WAIT) || (state_next == CHECK);
    done_next = (state_next == DONE);
    pass_next = done_next && (err_next == 8'd0);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lfsr_r  <= SEED;
      wait_r  <= 4'd0;
      err_r   <= 8'd0;
      vec_r   <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      lfsr_r  <= lfsr_next;
      wait_r  <= wait_next;
      err_r   <= err_next;
      vec_r   <= vec_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
      pass_r  <= pass_next;
    end
  end

  assign bus.op_a      = lfsr_r[15:8];
  assign bus.op_b      = lfsr_r[7:0];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_r;
  assign bus.vec_count = vec_r;

endmodule

// File: doc/adder_bist_driver.md
ADDER_BIST_DRIVER -- requirements
Module: adder_bist_driver

Interface
REQ-001 Parameter N_VECTORS, default 16, vectors per run; legal range 1..255.
REQ-002 Parameter LATENCY, default 0, wait cycles between driving operands and sampling the sum; legal range 0..15.
REQ-003 Design SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous reset, active high.
REQ-006 start  in  1  run request, sampled in IDLE or DONE.
REQ-007 sum_in  in  8  sum returned by the adder under test.
REQ-008 op_a  out  8  operand A to the adder under test.
REQ-009 op_b  out  8  operand B to the adder under test.
REQ-010 busy  out  1  high in DRIVE, WAIT and CHECK.
REQ-011 done  out  1  high in DONE only.
REQ-012 pass  out  1  high in DONE when err_count == 0; low in every other state.
REQ-013 err_count  out  8  mismatches in the current or last run, saturating.
REQ-014 vec_count  out  8  vectors checked in the current or last run.

Function
REQ-015 Block SHALL drive the adder input side with pseudo-random vectors and check the returned sum against (op_a + op_b) mod 256.
REQ-016 Pattern source SHALL be a 16-bit Fibonacci LFSR, seed 0xACE1, shifting left each step; new bit[0] = q[15]^q[13]^q[12]^q[10].
REQ-017 op_a SHALL equal lfsr[15:8] and op_b SHALL equal lfsr[7:0], both driven directly from registers and stable for a whole vector.
REQ-018 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-019 IDLE or DONE with start=1: go to DRIVE; reload LFSR with the seed; clear err_count and vec_count.
REQ-020 DRIVE SHALL last 1 cycle, then go to WAIT if LATENCY > 0, else to CHECK.
REQ-021 WAIT SHALL last exactly LATENCY cycles, counted by an internal 4-bit counter, then go to CHECK.
REQ-022 CHECK SHALL last 1 cycle; sum_in is sampled LATENCY+1 cycles after op_a/op_b become valid.
REQ-023 In CHECK, a mismatch SHALL increment err_count, saturating at 255.
REQ-024 In CHECK, vec_count SHALL increment and the LFSR SHALL advance one step.
REQ-025 After CHECK, if the new vec_count == N_VECTORS go to DONE, else go to DRIVE.
REQ-026 Each vector SHALL take exactly LATENCY+2 cycles; a run SHALL take N_VECTORS*(LATENCY+2) cycles from the first DRIVE cycle to DONE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 DONE SHALL hold done, pass, err_count and vec_count until start=1 or reset.
REQ-029 start=1 in DONE SHALL restart as in IDLE, with no intermediate IDLE cycle.
REQ-030 op_a and op_b SHALL keep their last values in IDLE and DONE.

Reset
REQ-031 rst=1 at any cycle, including mid-run, SHALL force IDLE on the next edge.
REQ-032 Reset SHALL set the LFSR to 0xACE1, so op_a=0xAC and op_b=0xE1.
REQ-033 Reset SHALL set err_count=0, vec_count=0, busy=0, done=0 and pass=0.
REQ-034 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-035 Correct adder model, LATENCY=0, start pulse -> vector 1 is 0xAC/0xE1 with expected 0x8D; vector 2 is 0x59/0xC3 with expected 0x1C; after 32 cycles done=1, pass=1, vec_count=16, err_count=0.
REQ-036 Adder model with sum bit0 stuck at 0 -> err_count equals the number of vectors with an odd expected sum, and pass=0.
REQ-037 LATENCY=3 with a 3-cycle pipelined adder model -> pass=1 and the run takes 80 cycles; the same model with LATENCY=2 -> err_count > 0.
REQ-038 Model always returning 0x00, N_VECTORS=255 -> err_count counts up to the number of nonzero expected sums and never wraps past 255.
REQ-039 rst asserted mid-run at vector 5 -> IDLE next cycle, op_a=0xAC, counts 0; a new start reproduces the vector sequence from 0xAC/0xE1.
REQ-040 start held high for the whole run -> no restart until DONE; in DONE the block restarts immediately, with done high for exactly 1 cycle.
